// File: rtl/axi4_lite_cmd_sequencer.sv
// Command front-end for axi4_lite_top. It buffers host commands in a FIFO and issues them one at a
// time. Read results, or a timeout error, come back on a valid/ready response stream.
module axi4_lite_cmd_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDRESS    = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WR_GAP     = 8,
   parameter int unsigned RD_TIMEOUT = 64
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [ADDRESS-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]         cmd_wdata,
   output logic                          read_s,
   output logic                          write_s,
   output logic [ADDRESS-1:0]            address,
   output logic [DATA_WIDTH-1:0]         W_data,
   input  logic [DATA_WIDTH-1:0]         read_data_out,
   input  logic                          read_valid_out,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_error,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam int unsigned WAIT_MAX = (RD_TIMEOUT > WR_GAP) ? RD_TIMEOUT : WR_GAP;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX) + 1;

   typedef struct packed {
      logic                  write;
      logic [ADDRESS-1:0]    addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;

   cmd_t                  mem_q [FIFO_DEPTH];
   cmd_t                  cmd_in_c;
   cmd_t                  head_c;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  cmd_ready_q;
   logic                  push_c;
   logic                  pop_c;

   state_t                state_q;
   logic                  is_wr_q;
   logic [WAIT_W-1:0]     wait_q;
   logic                  read_s_q;
   logic                  write_s_q;
   logic [ADDRESS-1:0]    address_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_error_q;

   // FIFO control. cmd_ready comes only from the registered count, so a full FIFO never pushes through.
   always_comb begin
      cmd_in_c       = '0;
      cmd_in_c.write = cmd_write;
      cmd_in_c.addr  = cmd_addr;
      cmd_in_c.wdata = cmd_wdata;
      head_c         = mem_q[rd_ptr_q];
      push_c         = cmd_valid && cmd_ready_q;
      pop_c          = (state_q == IDLE) && (count_q != '0);
      count_d        = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q     <= count_d;
         cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      end
   end

   // Sequencer FSM. Start pulses are set on entry to ISSUE, so they last exactly that one cycle.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         is_wr_q     <= 1'b0;
         wait_q      <= '0;
         read_s_q    <= 1'b0;
         write_s_q   <= 1'b0;
         address_q   <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop_c) begin
                  is_wr_q   <= head_c.write;
                  read_s_q  <= !head_c.write;
                  write_s_q <= head_c.write;
                  address_q <= head_c.addr;
                  wdata_q   <= head_c.write ? head_c.wdata : '0;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               read_s_q  <= 1'b0;
               write_s_q <= 1'b0;
               wait_q    <= '0;
               state_q   <= is_wr_q ? WAIT_WR : WAIT_RD;
            end
            WAIT_RD: begin
               wait_q <= wait_q + WAIT_W'(1);
               // Returned data takes priority over a timeout that expires in the same cycle.
               if (read_valid_out) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= read_data_out;
                  rsp_error_q <= 1'b0;
                  state_q     <= RESP;
               end else if (wait_q == WAIT_W'(RD_TIMEOUT - 1)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_error_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            WAIT_WR: begin
               wait_q <= wait_q + WAIT_W'(1);
               if (wait_q == WAIT_W'(WR_GAP - 1)) begin
                  state_q <= IDLE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign fifo_count = count_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign read_s     = read_s_q;
   assign write_s    = write_s_q;
   assign address    = address_q;
   assign W_data     = wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_error  = rsp_error_q;

endmodule
